// File: rtl/imem_program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The checksum helper is the single place where the byte-XOR rule is defined.
package imem_program_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int INSTR_W    = 16;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECV_LO = 3'd1,
        ST_RECV_HI = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RECV_CK = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } state_e;

    function automatic logic [BYTE_W-1:0] chk_accum(input logic [BYTE_W-1:0] chk,
                                                    input logic [BYTE_W-1:0] b);
        return chk ^ b;
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles little-endian byte pairs into an instruction word and keeps the
// running XOR of every payload byte seen since the last clear.
module imem_byte_packer
    import imem_program_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               lo_en,
    input  logic               hi_en,
    input  logic [BYTE_W-1:0]  rx_byte,
    output logic [INSTR_W-1:0] word,
    output logic [BYTE_W-1:0]  chk
);

    logic [BYTE_W-1:0] lo_r;
    logic [BYTE_W-1:0] hi_r;
    logic [BYTE_W-1:0] chk_r;

    // Byte latches and running checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_r  <= {BYTE_W{1'b0}};
            hi_r  <= {BYTE_W{1'b0}};
            chk_r <= {BYTE_W{1'b0}};
        end else if (clr) begin
            lo_r  <= {BYTE_W{1'b0}};
            hi_r  <= {BYTE_W{1'b0}};
            chk_r <= {BYTE_W{1'b0}};
        end else if (lo_en) begin
            lo_r  <= rx_byte;
            chk_r <= chk_accum(chk_r, rx_byte);
        end else if (hi_en) begin
            hi_r  <= rx_byte;
            chk_r <= chk_accum(chk_r, rx_byte);
        end else begin
            chk_r <= chk_r;
        end
    end

    assign word = {hi_r, lo_r};
    assign chk  = chk_r;

endmodule

// File: rtl/imem_program_loader.sv
// Loads a program byte stream into the instruction store, verifies a trailing
// XOR checksum and holds the CPU off until a load completes cleanly.
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 16,
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_e state_r;
    state_e state_nxt_s;

    logic [ADDR_W:0]    len_r;
    logic [ADDR_W:0]    cnt_r;
    logic [ADDR_W-1:0]  addr_r;
    logic               rx_ready_r;
    logic               mem_we_r;
    logic               cpu_hold_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;

    logic               xfer_s;
    logic               last_s;
    logic               len_bad_s;
    logic               ck_ok_s;
    logic               start_ok_s;
    logic               start_bad_s;
    logic               lo_take_s;
    logic               hi_take_s;
    logic               ck_good_s;
    logic               ck_bad_s;
    logic [INSTR_W-1:0] word_s;
    logic [BYTE_W-1:0]  chk_s;

    assign xfer_s    = rx_valid && rx_ready_r;
    assign last_s    = ((cnt_r + CNT_ONE) == len_r);
    assign len_bad_s = (load_len == {(ADDR_W+1){1'b0}}) || (load_len > DEPTH_L);
    assign ck_ok_s   = (chk_accum(chk_s, rx_data) == {BYTE_W{1'b0}});

    imem_byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok_s),
        .lo_en   (lo_take_s),
        .hi_en   (hi_take_s),
        .rx_byte (rx_data),
        .word    (word_s),
        .chk     (chk_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-cycle action strobes.
    always_comb begin
        state_nxt_s = state_r;
        start_ok_s  = 1'b0;
        start_bad_s = 1'b0;
        lo_take_s   = 1'b0;
        hi_take_s   = 1'b0;
        ck_good_s   = 1'b0;
        ck_bad_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (load_start && len_bad_s) begin
                    start_bad_s = 1'b1;
                    state_nxt_s = ST_ERR;
                end else if (load_start) begin
                    start_ok_s  = 1'b1;
                    state_nxt_s = ST_RECV_LO;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RECV_LO: begin
                if (xfer_s) begin
                    lo_take_s   = 1'b1;
                    state_nxt_s = ST_RECV_HI;
                end else begin
                    state_nxt_s = ST_RECV_LO;
                end
            end
            ST_RECV_HI: begin
                if (xfer_s) begin
                    hi_take_s   = 1'b1;
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_RECV_HI;
                end
            end
            ST_WRITE: begin
                if (last_s) begin
                    state_nxt_s = ST_RECV_CK;
                end else begin
                    state_nxt_s = ST_RECV_LO;
                end
            end
            ST_RECV_CK: begin
                if (xfer_s && ck_ok_s) begin
                    ck_good_s   = 1'b1;
                    state_nxt_s = ST_DONE;
                end else if (xfer_s) begin
                    ck_bad_s    = 1'b1;
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_RECV_CK;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, address and word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ready_r <= 1'b0;
            mem_we_r   <= 1'b0;
            cpu_hold_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            len_r      <= {(ADDR_W+1){1'b0}};
            cnt_r      <= {(ADDR_W+1){1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
        end else begin
            rx_ready_r <= (state_nxt_s == ST_RECV_LO) || (state_nxt_s == ST_RECV_HI) ||
                          (state_nxt_s == ST_RECV_CK);
            mem_we_r   <= (state_nxt_s == ST_WRITE);
            if (start_ok_s) begin
                len_r      <= load_len;
                cnt_r      <= {(ADDR_W+1){1'b0}};
                addr_r     <= {ADDR_W{1'b0}};
                busy_r     <= 1'b1;
                cpu_hold_r <= 1'b1;
                done_r     <= 1'b0;
                err_r      <= 1'b0;
            end else if (start_bad_s || ck_bad_s) begin
                busy_r     <= 1'b0;
                cpu_hold_r <= 1'b1;
                done_r     <= 1'b0;
                err_r      <= 1'b1;
            end else if (ck_good_s) begin
                busy_r     <= 1'b0;
                cpu_hold_r <= 1'b0;
                done_r     <= 1'b1;
                err_r      <= 1'b0;
            end else if (state_r == ST_WRITE) begin
                cnt_r <= cnt_r + CNT_ONE;
                // Final word keeps its address so the top address stays DEPTH-1.
                if (!last_s) begin
                    addr_r <= addr_r + ADDR_ONE;
                end
            end
        end
    end

    assign rx_ready  = rx_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = word_s;
    assign cpu_hold  = cpu_hold_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench: stimulus pushes expected memory writes into a queue and a
// negedge monitor pops and compares on every mem_we pulse.
module tb_imem_program_loader;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_start = 1'b0;
    logic [ADDR_W:0]   load_len = 5'd0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    int          checks = 0;
    int          errors = 0;
    int          we_total = 0;
    int          snap = 0;
    logic [19:0] exp_q[$];
    logic [15:0] prog_w [16];

    imem_program_loader #(.ADDR_W(4), .DEPTH(16), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin : mon
        logic [19:0] e;
        if (mem_we === 1'b1) begin
            we_total++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL mem_write: got addr %0h data %0h expected addr %0h data %0h",
                             mem_addr, mem_wdata, e[19:16], e[15:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: got rx_ready 0 expected 1 within 50 cycles");
        end else begin
            @(posedge clk);
        end
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic start_load(input logic [ADDR_W:0] len);
        @(negedge clk);
        load_start = 1'b1;
        load_len   = len;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic run_payload(input int n, input int gap_max, input logic [7:0] ck_flip,
                               input int pulse_word);
        logic [7:0] ck;
        ck = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({4'(i), prog_w[i]});
            ck = ck ^ prog_w[i][7:0] ^ prog_w[i][15:8];
            if (i == pulse_word) begin
                @(negedge clk);
                load_start = 1'b1;
                load_len   = 5'd3;
                @(negedge clk);
                load_start = 1'b0;
            end
            send_byte(prog_w[i][7:0], int'($urandom_range(0, gap_max)));
            send_byte(prog_w[i][15:8], int'($urandom_range(0, gap_max)));
        end
        send_byte(ck ^ ck_flip, int'($urandom_range(0, gap_max)));
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err}), 32'd0);
        rst = 1'b0;

        // Two-word load: checksum 42^44^C1^44 = 83.
        prog_w[0] = 16'h4442;
        prog_w[1] = 16'h44C1;
        snap = we_total;
        start_load(5'd2);
        check("t1_start_status", 32'({rx_ready, cpu_hold, busy, done, err}), 32'b11100);
        run_payload(2, 0, 8'h00, -1);
        check("t1_status", 32'({rx_ready, cpu_hold, busy, done, err}), 32'b00010);
        check("t1_write_count", 32'(we_total - snap), 32'd2);

        // Ten-word load with random rx_valid gaps.
        prog_w[0] = 16'h1234; prog_w[1] = 16'hABCD; prog_w[2] = 16'h0F0F; prog_w[3] = 16'hF00D;
        prog_w[4] = 16'h0001; prog_w[5] = 16'h8000; prog_w[6] = 16'h5A5A; prog_w[7] = 16'hC3A5;
        prog_w[8] = 16'h7E81; prog_w[9] = 16'hFFFF;
        snap = we_total;
        start_load(5'd10);
        run_payload(10, 3, 8'h00, -1);
        check("t2_status", 32'({cpu_hold, busy, done, err}), 32'b0010);
        check("t2_write_count", 32'(we_total - snap), 32'd10);

        // Bad checksum, then a good reload.
        prog_w[0] = 16'h1111; prog_w[1] = 16'h2222; prog_w[2] = 16'h3344;
        start_load(5'd3);
        run_payload(3, 1, 8'h01, -1);
        check("t3_bad_ck_status", 32'({cpu_hold, busy, done, err}), 32'b1001);
        start_load(5'd3);
        check("t3_reload_start", 32'({cpu_hold, busy, done, err}), 32'b1100);
        run_payload(3, 1, 8'h00, -1);
        check("t3_reload_status", 32'({cpu_hold, busy, done, err}), 32'b0010);

        // Illegal lengths.
        snap = we_total;
        start_load(5'd0);
        check("t4_len0_status", 32'({rx_ready, cpu_hold, busy, done, err}), 32'b01001);
        repeat (3) @(negedge clk);
        check("t4_len0_idle", 32'({rx_ready, mem_we}), 32'd0);
        start_load(5'd17);
        check("t4_len17_status", 32'({rx_ready, cpu_hold, busy, done, err}), 32'b01001);
        repeat (3) @(negedge clk);
        check("t4_len17_ready", 32'(rx_ready), 32'd0);
        check("t4_no_writes", 32'(we_total - snap), 32'd0);

        // load_start pulsed mid-load must be ignored.
        prog_w[0] = 16'hA1B2; prog_w[1] = 16'hC3D4; prog_w[2] = 16'hE5F6;
        prog_w[3] = 16'h0718; prog_w[4] = 16'h292A;
        snap = we_total;
        start_load(5'd5);
        run_payload(5, 1, 8'h00, 2);
        check("t5_status", 32'({cpu_hold, busy, done, err}), 32'b0010);
        check("t5_write_count", 32'(we_total - snap), 32'd5);

        // Async reset after three bytes: word 0 written, partial word 1 not.
        snap = we_total;
        start_load(5'd2);
        exp_q.push_back({4'd0, 16'h4442});
        send_byte(8'h42, 0);
        send_byte(8'h44, 0);
        send_byte(8'hC1, 0);
        check("t6_hold_before_rst", 32'({cpu_hold, busy}), 32'b11);
        #1;
        rst = 1'b1;
        #1;
        check("t6_async_reset", 32'({rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err}), 32'd0);
        repeat (3) @(negedge clk);
        check("t6_write_count", 32'(we_total - snap), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
